// File: rtl/half_subtractor_behavioral_pkg.sv
// Shared arithmetic-library defaults for the half subtractor leaf.
package half_subtractor_behavioral_pkg;

  localparam int unsigned HS_DEF_WIDTH = 1;
  localparam int unsigned HS_DEF_CNT_W = 8;

endpackage

// File: rtl/fs_bit.sv
// One-bit full subtractor: d = a - b - bin, bout set when the stage borrows.
module fs_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  always_comb begin
    d    = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/half_subtractor_behavioral.sv
// Width-parameterised half subtractor with combinational result, registered
// copy and a saturating count of borrow cycles.
module half_subtractor_behavioral
  import half_subtractor_behavioral_pkg::*;
#(
  parameter int unsigned WIDTH = HS_DEF_WIDTH,
  parameter int unsigned CNT_W = HS_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] diff,
  output logic             c_out,
  output logic [WIDTH-1:0] diff_q,
  output logic             c_out_q,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (WIDTH == 1) begin : g_single
      always_comb begin
        diff  = x ^ y;
        c_out = ~x[0] & y[0];
      end
    end else begin : g_ripple
      logic [WIDTH:0] borrow;

      assign borrow[0] = 1'b0;
      assign c_out     = borrow[WIDTH];

      // Stage 0 sees bin = 0, so it degenerates to a half subtractor.
      for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        fs_bit u_fs (
          .a    (x[i]),
          .b    (y[i]),
          .bin  (borrow[i]),
          .d    (diff[i]),
          .bout (borrow[i+1])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q     <= '0;
      c_out_q    <= 1'b0;
      borrow_cnt <= '0;
    end else begin
      diff_q  <= diff;
      c_out_q <= c_out;
      if (c_out && (borrow_cnt != CNT_MAX)) begin
        borrow_cnt <= borrow_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_half_subtractor_behavioral.sv
// Directed-vector bench for half_subtractor_behavioral at three parameter points.
module tb_half_subtractor_behavioral;

  logic clk;
  logic rst_n;

  logic       x1, y1, diff1, c1, dq1, cq1;
  logic [7:0] cnt1;

  logic       xs, ys, diffs, cs, dqs, cqs;
  logic [1:0] cnts;

  logic [3:0] x4, y4, diff4, dq4;
  logic       c4, cq4;
  logic [7:0] cnt4;

  int unsigned n_cmp;
  int unsigned n_err;

  half_subtractor_behavioral #(.WIDTH(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1),
    .diff(diff1), .c_out(c1), .diff_q(dq1), .c_out_q(cq1), .borrow_cnt(cnt1)
  );

  half_subtractor_behavioral #(.WIDTH(1), .CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .x(xs), .y(ys),
    .diff(diffs), .c_out(cs), .diff_q(dqs), .c_out_q(cqs), .borrow_cnt(cnts)
  );

  half_subtractor_behavioral #(.WIDTH(4), .CNT_W(8)) u_w4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4),
    .diff(diff4), .c_out(c4), .diff_q(dq4), .c_out_q(cq4), .borrow_cnt(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] comb_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
  logic [1:0] sat_exp  [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    x1 = 1'b0; y1 = 1'b0;
    xs = 1'b0; ys = 1'b0;
    x4 = 4'd0; y4 = 4'd0;

    // truth table of the 1-bit combinational path, reset held
    for (int i = 0; i < 4; i++) begin
      x1 = i[1];
      y1 = i[0];
      #100;
      check("comb_w1", 32'({diff1, c1}), 32'(comb_exp[i]));
    end

    x4 = 4'd3; y4 = 4'd5;
    #1;
    check("w4_diff_3m5", 32'(diff4), 32'd14);
    check("w4_cout_3m5", 32'(c4), 32'd1);
    x4 = 4'd9; y4 = 4'd4;
    #1;
    check("w4_diff_9m4", 32'(diff4), 32'd5);
    check("w4_cout_9m4", 32'(c4), 32'd0);

    x1 = 1'b0; y1 = 1'b1;
    #1;
    check("rst_comb_diff", 32'(diff1), 32'd1);
    check("rst_comb_cout", 32'(c1), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_diff_q", 32'(dq1), 32'd0);
    check("rst_cout_q", 32'(cq1), 32'd0);
    check("rst_cnt", 32'(cnt1), 32'd0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("first_diff_q", 32'(dq1), 32'd1);
    check("first_cout_q", 32'(cq1), 32'd1);
    check("first_cnt", 32'(cnt1), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("cnt_after3", 32'(cnt1), 32'd3);

    @(negedge clk) begin x1 = 1'b1; y1 = 1'b0; end
    @(posedge clk) #1;
    check("hold_diff_q", 32'(dq1), 32'd1);
    check("hold_cout_q", 32'(cq1), 32'd0);
    check("hold_cnt", 32'(cnt1), 32'd3);

    @(negedge clk) ys = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk) #1;
      check($sformatf("sat_cnt_%0d", i), 32'(cnts), 32'(sat_exp[i]));
    end
    @(negedge clk) ys = 1'b0;

    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) begin rst_n = 1'b1; x1 = 1'b0; y1 = 1'b1; end
    repeat (2) @(posedge clk);
    #1;
    check("pre_async_cnt", 32'(cnt1), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(cnt1), 32'd0);
    check("async_diff_q", 32'(dq1), 32'd0);
    check("async_cout_q", 32'(cq1), 32'd0);
    check("async_sat_cnt", 32'(cnts), 32'd0);
    check("async_comb_cout", 32'(c1), 32'd1);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk) #1;
    check("release_cnt", 32'(cnt1), 32'd1);
    check("release_cout_q", 32'(cq1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/half_subtractor_behavioral.md
# half_subtractor_behavioral

Single-bit-default, width-parameterised half subtractor, described behaviourally. It computes x − y with a borrow out and presents the result on a zero-latency combinational path, with no dependency on clock or reset. It also provides a registered copy of the result and a saturating borrow-event counter for use in pipelined datapaths. It sits at the leaf level of the arithmetic library, beneath the full-subtractor and ripple-subtractor blocks.

## Interface
- WIDTH, default 1: operand and difference width in bits.
- CNT_W, default 8: width of the borrow-event counter.
- clk  input  1  rising-edge clock for the registered outputs only.
- rst_n  input  1  reset, asynchronous and active-low; clears all registered state.
- x  input  WIDTH  minuend.
- y  input  WIDTH  subtrahend.
- diff  output  WIDTH  combinational difference, (x − y) mod 2^WIDTH.
- c_out  output  1  combinational borrow out; 1 when x < y (unsigned).
- diff_q  output  WIDTH  diff registered on clk.
- c_out_q  output  1  c_out registered on clk.
- borrow_cnt  output  CNT_W  number of clock edges on which c_out was 1; saturates.

## Operation
- WIDTH = 1 case:
  - diff = x XOR y.
  - c_out = (NOT x) AND y.
- WIDTH > 1 case:
  - Unsigned ripple subtraction: bit 0 is a half subtractor, higher bits are full-subtractor stages fed by the borrow of the previous bit.
  - c_out is the final borrow.
  - Equivalently, {c_out, diff} = {1'b0, x} − {1'b0, y}, truncated to WIDTH+1 bits with borrow meaning a negative result.
- The combinational path (diff, c_out) is independent of clk and rst_n:
  - It must be valid with clk and rst_n unconnected or X.
  - It must be valid while reset is asserted.
- Registered path, at each rising clk edge with rst_n high:
  - diff_q ← diff.
  - c_out_q ← c_out.
  - If c_out = 1 and borrow_cnt < 2^CNT_W − 1, then borrow_cnt ← borrow_cnt + 1. Otherwise borrow_cnt holds.
- Saturation: borrow_cnt stops at all-ones and never wraps to 0.
- X or Z inputs give no defined output and need no special handling.

## Timing
- diff and c_out: 0 cycles; purely combinational from x and y.
- diff_q, c_out_q, borrow_cnt: 1-cycle latency; they reflect the inputs sampled at the previous rising edge.
- Reset values: diff_q = 0, c_out_q = 0, borrow_cnt = 0.
- Reset assertion (rst_n falling) clears the registered outputs immediately, without waiting for clk. This includes reset asserted mid-stream.
- Reset release: the first rising edge with rst_n high loads the current inputs.
- Input changes between clock edges affect only diff and c_out.

## Structure
- No shared package is required. Only the default WIDTH and CNT_W values may go into the library's common arithmetic constants package.
- Sub-module: fs_bit, a 1-bit full subtractor with inputs a, b, bin and outputs d, bout.
  - Stage 0 instantiates it with bin = 0, which gives the half-subtractor function.
  - The behavioural top level may instead use a direct always @* expression for WIDTH = 1.
- Keep the combinational core and the register/counter block in separate always blocks.

## Test plan
- WIDTH = 1, clock and reset unconnected, x,y stepping through 00, 01, 10, 11 with 100 ns each -> diff,c_out = 0,0; 1,1; 1,0; 0,0.
- Hold rst_n = 0 and apply x = 0, y = 1 -> diff = 1 and c_out = 1 immediately; diff_q = 0, c_out_q = 0, borrow_cnt = 0.
- Release reset, then apply x = 0, y = 1 for 3 cycles -> diff_q = 1 and c_out_q = 1 one edge later; borrow_cnt = 3.
- CNT_W = 2, hold c_out = 1 for 6 cycles -> borrow_cnt steps 1, 2, 3, then stays at 3.
- WIDTH = 4, x = 4'd3, y = 4'd5 -> diff = 4'd14, c_out = 1. Then x = 4'd9, y = 4'd4 -> diff = 4'd5, c_out = 0.
- Assert rst_n asynchronously between edges while borrow_cnt = 2 -> all registered outputs read 0 before the next clk edge.
